// File: rtl/tag_release_table.sv
// Out-of-order completion tracker. Tags are allocated in issue order and
// retired by tag match in any order; among duplicate tags the oldest is
// retired first. Lookup ports report conflicts against outstanding tags.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   alloc_*            allocate a tag (ready = table not full)
//   release_*          retire the oldest entry matching release_data_i
//                      (ready = some valid entry matches, independent of valid)
//   lookup_data_i      per-port tag to test
//   lookup_match_o     per-port: some valid entry equals the tag
//   count_o            number of valid entries
//   empty_o, full_o    count_o == 0, count_o == DEPTH
module tag_release_table #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned LOOKUP_PORTS = 1,
    parameter type         dtype        = logic [DATA_WIDTH-1:0]
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         alloc_valid_i,
    output logic                         alloc_ready_o,
    input  dtype                         alloc_data_i,
    input  logic                         release_valid_i,
    output logic                         release_ready_o,
    input  dtype                         release_data_i,
    input  dtype                         lookup_data_i [LOOKUP_PORTS],
    output logic [LOOKUP_PORTS-1:0]      lookup_match_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid_q;
    dtype             tag_q [DEPTH];
    logic [AW-1:0]    age_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic             full_q;
    logic             empty_q;

    logic [DEPTH-1:0] valid_d;
    dtype             tag_d [DEPTH];
    logic [AW-1:0]    age_d [DEPTH];
    logic [CW-1:0]    count_d;

    logic [AW-1:0]    free_idx;
    logic             free_found;
    logic [AW-1:0]    victim_idx;
    logic [AW-1:0]    victim_age;
    logic             rel_hit;
    logic             alloc_fire;
    logic             rel_fire;

    // Lowest-index invalid entry, from pre-cycle state.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (!valid_q[i] && !free_found) begin
                free_idx   = AW'(i);
                free_found = 1'b1;
            end
        end
    end

    // Oldest (largest age) valid entry matching the release tag.
    always_comb begin
        victim_idx = '0;
        victim_age = '0;
        rel_hit    = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i] && (tag_q[i] == release_data_i) &&
                (!rel_hit || (age_q[i] > victim_age))) begin
                victim_idx = AW'(i);
                victim_age = age_q[i];
                rel_hit    = 1'b1;
            end
        end
    end

    assign alloc_fire = alloc_valid_i && !full_q;
    assign rel_fire   = release_valid_i && rel_hit;

    // Next entry state: release decrement first, then alloc increment of survivors.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            valid_d[i] = valid_q[i];
            tag_d[i]   = tag_q[i];
            age_d[i]   = age_q[i];
            if (rel_fire) begin
                if (AW'(i) == victim_idx) begin
                    valid_d[i] = 1'b0;
                end else if (valid_q[i] && (age_q[i] > victim_age)) begin
                    age_d[i] = age_q[i] - AW'(1);
                end
            end
            if (alloc_fire) begin
                if (valid_d[i]) begin
                    age_d[i] = age_d[i] + AW'(1);
                end else if (AW'(i) == free_idx) begin
                    // free_idx was invalid pre-cycle, so it is never this cycle's victim
                    valid_d[i] = 1'b1;
                    tag_d[i]   = alloc_data_i;
                    age_d[i]   = '0;
                end
            end
        end
        count_d = count_q + CW'(alloc_fire) - CW'(rel_fire);
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i] <= '0;
                age_q[i] <= '0;
            end
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i] <= tag_d[i];
                age_q[i] <= age_d[i];
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Conflict lookup over registered entries only.
    always_comb begin
        lookup_match_o = '0;
        for (int p = 0; p < int'(LOOKUP_PORTS); p++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (valid_q[i] && (tag_q[i] == lookup_data_i[p])) begin
                    lookup_match_o[p] = 1'b1;
                end
            end
        end
    end

    assign release_ready_o = rel_hit;
    assign alloc_ready_o   = !full_q;
    assign count_o         = count_q;
    assign full_o          = full_q;
    assign empty_o         = empty_q;

endmodule

// File: doc/tag_release_table.md
# tag_release_table

Out-of-order completion tracker for the CCU: entries are allocated in order when a transaction is issued and released by tag match when its response returns, in any order. It is the response-side counterpart of the in-order lookup FIFO: the issuing path allocates, the response path retires, and lookup ports let other paths detect conflicts against outstanding tags. Among duplicate tags, release always retires the oldest matching entry, so the response ordering of same-tag transactions is preserved.

## Interface
- DEPTH, 4: number of entries; must be ≥ 2.
- DATA_WIDTH, 32: tag width when dtype is not overridden.
- LOOKUP_PORTS, 1: number of independent conflict-lookup ports.
- dtype, logic [DATA_WIDTH-1:0]: stored tag type; compared with ==.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- alloc_valid_i  in  1  allocation request.
- alloc_ready_o  out  1  table not full.
- alloc_data_i  in  dtype  tag to store.
- release_valid_i  in  1  release request.
- release_ready_o  out  1  a valid entry matches release_data_i.
- release_data_i  in  dtype  tag to retire.
- lookup_data_i  in  dtype[LOOKUP_PORTS]  tags to test.
- lookup_match_o  out  LOOKUP_PORTS  per port: some valid entry equals the tag.
- count_o  out  $clog2(DEPTH+1)  number of valid entries.
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == DEPTH.

## Operation
- State per entry: valid bit, tag, age counter of width $clog2(DEPTH). Age = number of valid entries allocated after this one; always in 0..count-1, unique among valid entries.
- Alloc fires on alloc_valid_i && alloc_ready_o; alloc_ready_o = !full_o. The tag is written to the lowest-index invalid entry, with age 0. Every other entry still valid after this cycle has its age incremented.
- Release fires on release_valid_i && release_ready_o. release_ready_o is combinational from release_data_i and registered state only; it does not depend on release_valid_i.
  - The victim is the matching valid entry with the largest age, i.e. the oldest.
  - The victim is invalidated; every valid entry with age greater than the victim's is decremented.
- An unmatched release stalls: ready stays 0 and no state changes. The requester holds valid until a matching allocation becomes visible.
- Simultaneous alloc and release in one cycle:
  - Slot choice and full check use pre-cycle state. A full table refuses alloc even if a release fires in the same cycle.
  - The released slot cannot be reused in the same cycle.
  - Ages apply the release decrement first, then the alloc increment to all survivors; the new entry gets age 0.
  - count_o is unchanged.
- Lookup is purely combinational over registered valid entries. It excludes an allocation in the same cycle and still includes an entry being released in the same cycle.
- Invalid entries never match. Their tag contents are don't-care but are reset to '0.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): all valid bits, ages and tags are 0. Outputs after reset: count_o=0, empty_o=1, full_o=0, alloc_ready_o=1, release_ready_o=0, lookup_match_o=0.
- Reset asserted mid-operation clears all entries immediately; in-flight handshakes are dropped.
- Alloc latency: the entry becomes visible to lookup and release, and is reflected in count, starting the cycle after the handshake. There is no fall-through.
- Release latency: the entry disappears from lookup and count the cycle after the handshake. A back-to-back release of the same tag then sees the next-oldest duplicate.
- Throughput: one alloc plus one release per cycle, sustained.

## Test plan
- Reset, then alloc tags 0xA, 0xB, 0xC, 0xD on consecutive cycles:
  - full_o=1, count_o=4 after the 4th alloc.
  - alloc_ready_o=0; a 5th alloc of 0xE is not accepted.
  - lookup 0xC → match=1; lookup 0xE → match=0.
- From that state, release 0xC, then 0xA:
  - Each handshake completes in one cycle and count_o steps 3, then 2.
  - Alloc 0xE then lands in slot 0 (the lowest free index).
  - Lookup 0xC → 0.
- Duplicates: alloc 0x5 (tag X), 0x7, 0x5 (tag Y) → release 0x5 retires the first 0x5. Confirm via internal ages: the remaining 0x5 has age 0 and 0x7 has age 1.
- Release 0x9 on a table not containing it:
  - release_ready_o=0 and state unchanged for 3 cycles.
  - Alloc 0x9 → release_ready_o rises the following cycle, and the release completes.
- Full table with alloc_valid_i and a matching release asserted in the same cycle:
  - The release fires and the alloc is refused; count_o goes 4→3.
  - Next cycle the alloc fires; count_o returns to 4.
- Table with 3 entries, concurrent alloc 0x1 and release of an existing tag:
  - count_o stays 3.
  - lookup 0x1 = 0 during that cycle and 1 the next.
  - Assert rst_ni low mid-stream → all outputs return to reset values asynchronously.
